// File: rtl/cache_ctrl_pkg.sv
// Shared types and widths for the data-cache miss controller.
package cache_ctrl_pkg;
    localparam int XLEN  = 32;
    localparam int TAG_W = 19;
    localparam int IDX_W = 11;

    localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

    typedef enum logic [1:0] {IDLE, WBACK, REFILL, INSTALL} ctrl_state_t;
    typedef logic [3:0][7:0] word_t;
endpackage

// File: rtl/cache_ctrl_perf.sv
// Saturating hit/miss/writeback counters; only built with CACHE_CTRL_PERF_EN.
module cache_ctrl_perf
    import cache_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            hit_ev,
    input  logic            miss_ev,
    input  logic            wback_ev,
    input  logic            install_ev,
    output logic [XLEN-1:0] perf_hits,
    output logic [XLEN-1:0] perf_misses,
    output logic [XLEN-1:0] perf_wbacks
);
    // The hit right after INSTALL is the miss completing, not a new hit.
    logic after_install;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            after_install <= 1'b0;
            perf_hits     <= '0;
            perf_misses   <= '0;
            perf_wbacks   <= '0;
        end else begin
            after_install <= install_ev;
            if (hit_ev && !after_install && perf_hits != '1)
                perf_hits <= perf_hits + 1'b1;
            if (miss_ev && perf_misses != '1)
                perf_misses <= perf_misses + 1'b1;
            if (wback_ev && perf_wbacks != '1)
                perf_wbacks <= perf_wbacks + 1'b1;
        end
    end
endmodule

// File: rtl/cache_ctrl.sv
// Miss handler for a direct-mapped 1-word-line data cache: hits pass through,
// misses write back a dirty victim then refill. Counters under CACHE_CTRL_PERF_EN.
module cache_ctrl
    import cache_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic            req_we,
    input  logic            req_is_byte,
    input  logic [XLEN-1:0] req_addr,
    input  word_t           req_wdata,
    output word_t           cpu_rdata,
    output logic            cpu_stall,
    output logic [XLEN-1:0] cache_addr,
    output logic            cache_we,
    output logic            cache_is_byte,
    output word_t           cache_wdata,
    input  word_t           cache_rdata,
    input  logic            cache_hit,
    input  logic            cache_dirty,
    input  logic [XLEN-1:0] cache_victim,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] perf_hits,
    output logic [XLEN-1:0] perf_misses,
    output logic [XLEN-1:0] perf_wbacks
);
    ctrl_state_t     state, state_nxt;
    logic [XLEN-1:0] victim_addr, miss_addr;
    word_t           victim_word, refill_word;
    logic            idle, hit_done, miss_start;

    assign idle       = (state == IDLE);
    assign hit_done   = idle & req_valid & cache_hit;
    assign miss_start = idle & req_valid & ~cache_hit;
    assign cpu_stall  = req_valid & ~(idle & cache_hit);
    assign cpu_rdata  = cache_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Miss address is captured so the refill finishes even if the CPU drops the request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            victim_addr <= '0;
            victim_word <= '0;
            miss_addr   <= '0;
            refill_word <= '0;
        end else begin
            if (miss_start) begin
                victim_addr <= cache_victim & WORD_MASK;
                victim_word <= cache_rdata;
                miss_addr   <= req_addr;
            end
            if (state == REFILL && mem_ack)
                refill_word <= mem_rdata;
        end
    end

    always_comb begin
        state_nxt     = state;
        cache_addr    = miss_addr;
        cache_we      = 1'b0;
        cache_is_byte = 1'b0;
        cache_wdata   = '0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        case (state)
            IDLE: begin
                cache_addr    = req_addr;
                // Full-word read on a miss so the victim word can be captured.
                cache_is_byte = req_is_byte & ~miss_start;
                cache_wdata   = req_wdata;
                cache_we      = hit_done & req_we;
                if (miss_start)
                    state_nxt = cache_dirty ? WBACK : REFILL;
            end
            WBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = victim_addr;
                mem_wdata = victim_word;
                if (mem_ack) state_nxt = REFILL;
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = miss_addr & WORD_MASK;
                if (mem_ack) state_nxt = INSTALL;
            end
            INSTALL: begin
                cache_we    = 1'b1;
                cache_wdata = refill_word;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef CACHE_CTRL_PERF_EN
    cache_ctrl_perf u_perf (
        .clk        (clk),
        .rst        (rst),
        .hit_ev     (hit_done),
        .miss_ev    (miss_start),
        .wback_ev   ((state == WBACK) & mem_ack),
        .install_ev (state == INSTALL),
        .perf_hits  (perf_hits),
        .perf_misses(perf_misses),
        .perf_wbacks(perf_wbacks)
    );
`else
    assign perf_hits   = '0;
    assign perf_misses = '0;
    assign perf_wbacks = '0;
`endif
endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a behavioural direct-mapped cache and a fixed-latency memory.
module tb_cache_ctrl;
    import cache_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, req_is_byte;
    logic [31:0] req_addr;
    word_t       req_wdata, cpu_rdata, cache_wdata, cache_rdata;
    logic        cpu_stall, cache_we, cache_is_byte, cache_hit, cache_dirty;
    logic [31:0] cache_addr, cache_victim;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] perf_hits, perf_misses, perf_wbacks;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cache_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_is_byte(req_is_byte),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .cache_addr(cache_addr), .cache_we(cache_we), .cache_is_byte(cache_is_byte),
        .cache_wdata(cache_wdata), .cache_rdata(cache_rdata), .cache_hit(cache_hit),
        .cache_dirty(cache_dirty), .cache_victim(cache_victim),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .perf_hits(perf_hits), .perf_misses(perf_misses), .perf_wbacks(perf_wbacks)
    );

    // Behavioural cache: 2048 one-word lines.
    bit              c_valid [2048];
    bit              c_dirty [2048];
    bit [18:0]       c_tag   [2048];
    bit [3:0][7:0]   c_data  [2048];
    bit              pl_en = 1'b0;
    logic [31:0]     pl_addr;
    logic [31:0]     pl_data;
    bit              pl_dirty;
    logic [3:0][7:0] c_word;
    logic [7:0]      c_byte;

    assign cache_hit    = c_valid[cache_addr[12:2]] && (c_tag[cache_addr[12:2]] == cache_addr[31:13]);
    assign cache_dirty  = c_valid[cache_addr[12:2]] && c_dirty[cache_addr[12:2]];
    assign cache_victim = {c_tag[cache_addr[12:2]], cache_addr[12:2], 2'b00};
    assign c_word       = c_data[cache_addr[12:2]];
    assign c_byte       = c_word[cache_addr[1:0]];
    assign cache_rdata  = cache_is_byte ? {{24{c_byte[7]}}, c_byte} : c_word;

    always @(posedge clk) begin
        if (pl_en) begin
            c_valid[pl_addr[12:2]] <= 1'b1;
            c_tag[pl_addr[12:2]]   <= pl_addr[31:13];
            c_data[pl_addr[12:2]]  <= pl_data;
            c_dirty[pl_addr[12:2]] <= pl_dirty;
        end else if (cache_we) begin
            if (cache_hit) begin
                if (cache_is_byte) c_data[cache_addr[12:2]][cache_addr[1:0]] <= cache_wdata[0];
                else               c_data[cache_addr[12:2]] <= cache_wdata;
                c_dirty[cache_addr[12:2]] <= 1'b1;
            end else begin
                c_valid[cache_addr[12:2]] <= 1'b1;
                c_tag[cache_addr[12:2]]   <= cache_addr[31:13];
                c_data[cache_addr[12:2]]  <= cache_wdata;
                c_dirty[cache_addr[12:2]] <= 1'b0;
            end
        end
    end

    // Memory: acks `lat` cycles after mem_req rises; logs every completed transaction.
    int          lat = 3;
    bit          inject_ack = 1'b0;
    int          mcnt = 0;
    int          n_tx = 0;
    logic        tx_we   [16];
    logic [31:0] tx_addr [16];
    logic [31:0] tx_data [16];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0001_2004: return 32'hDEAD_BEEF;
            32'h0000_4004: return 32'h5566_7788;
            default:       return ~a;
        endcase
    endfunction

    always @(negedge clk) begin
        mem_ack = inject_ack;
        if (mem_req && !rst) begin
            mcnt++;
            if (mcnt >= lat) begin
                mcnt = 0;
                mem_ack = 1'b1;
                mem_rdata = mem_word(mem_addr);
                if (n_tx < 16) begin
                    tx_we[n_tx]   = mem_we;
                    tx_addr[n_tx] = mem_addr;
                    tx_data[n_tx] = mem_we ? mem_wdata : mem_rdata;
                end
                n_tx++;
            end
        end else begin
            mcnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d, input bit dty);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d; pl_dirty = dty;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Presents a request and waits for completion; returns stalled cycles and cache writes seen.
    task automatic run_req(input logic [31:0] a, input bit we, input bit byt, input logic [31:0] wd,
                           output int stalls, output int wes);
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_we = we; req_is_byte = byt; req_wdata = wd;
        #1;
        stalls = 0; wes = 0;
        while (cpu_stall && stalls < 50) begin
            if (cache_we) wes++;
            stalls++;
            @(negedge clk); #1;
        end
        if (cpu_stall) chk("req_timeout", 32'(cpu_stall), 32'd0);
    endtask

    task automatic drop_req();
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0; req_is_byte = 1'b0;
    endtask

    int st, ws, base;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_is_byte = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_cache_we", 32'(cache_we), 32'd0);
        chk("rst_perf_hits", perf_hits, 32'd0);

        // load hit
        preload(32'h0000_0010, 32'hCAFE_F00D, 1'b0);
        base = n_tx;
        run_req(32'h0000_0010, 1'b0, 1'b0, 32'h0, st, ws);
        chk("hit_stalls", 32'(st), 32'd0);
        chk("hit_rdata", cpu_rdata, 32'hCAFE_F00D);
        chk("hit_mem_req", 32'(mem_req), 32'd0);
        chk("hit_cache_we", 32'(cache_we), 32'd0);
        drop_req();
        #1 chk("hit_no_tx", 32'(n_tx - base), 32'd0);

        // clean miss: 1 + 3 + 1 stalled cycles, one read
        base = n_tx;
        run_req(32'h0001_2004, 1'b0, 1'b0, 32'h0, st, ws);
        chk("clean_stalls", 32'(st), 32'd5);
        chk("clean_install_we", 32'(ws), 32'd1);
        chk("clean_rdata", cpu_rdata, 32'hDEAD_BEEF);
        chk("clean_ntx", 32'(n_tx - base), 32'd1);
        chk("clean_tx_we", 32'(tx_we[base]), 32'd0);
        chk("clean_tx_addr", tx_addr[base], 32'h0001_2004);
        drop_req();

        // dirty miss: writeback then refill, 1 + 3 + 3 + 1 stalled cycles
        preload(32'h0000_2004, 32'h1122_3344, 1'b1);
        base = n_tx;
        run_req(32'h0000_4004, 1'b0, 1'b0, 32'h0, st, ws);
        chk("dirty_stalls", 32'(st), 32'd8);
        chk("dirty_ntx", 32'(n_tx - base), 32'd2);
        chk("dirty_wb_we", 32'(tx_we[base]), 32'd1);
        chk("dirty_wb_addr", tx_addr[base], 32'h0000_2004);
        chk("dirty_wb_data", tx_data[base], 32'h1122_3344);
        chk("dirty_rd_we", 32'(tx_we[base+1]), 32'd0);
        chk("dirty_rd_addr", tx_addr[base+1], 32'h0000_4004);
        chk("dirty_rdata", cpu_rdata, 32'h5566_7788);
        drop_req();

        // byte store hit, then byte and word reloads
        run_req(32'h0000_0013, 1'b1, 1'b1, 32'h0000_0080, st, ws);
        chk("bst_stalls", 32'(st), 32'd0);
        chk("bst_cache_we", 32'(cache_we), 32'd1);
        chk("bst_is_byte", 32'(cache_is_byte), 32'd1);
        run_req(32'h0000_0013, 1'b0, 1'b1, 32'h0, st, ws);
        chk("bld_cache_we", 32'(cache_we), 32'd0);
        chk("bld_rdata", cpu_rdata, 32'hFFFF_FF80);
        run_req(32'h0000_0010, 1'b0, 1'b0, 32'h0, st, ws);
        chk("bld_word", cpu_rdata, 32'h80FE_F00D);
        drop_req();

        // reset during REFILL; a late ack must be ignored
        lat = 100;
        base = n_tx;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0002_0008; req_we = 1'b0; req_is_byte = 1'b0;
        #1 chk("rr_stall", 32'(cpu_stall), 32'd1);
        @(negedge clk); #1;
        chk("rr_mem_req", 32'(mem_req), 32'd1);
        chk("rr_mem_addr", mem_addr, 32'h0002_0008);
        rst = 1'b1; req_valid = 1'b0;
        #1;
        chk("rr_mem_req_drop", 32'(mem_req), 32'd0);
        chk("rr_cache_we_drop", 32'(cache_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 inject_ack = 1'b1;
        @(negedge clk);
        #1 inject_ack = 1'b0;
        @(negedge clk); #1;
        chk("rr_late_mem_req", 32'(mem_req), 32'd0);
        chk("rr_late_cache_we", 32'(cache_we), 32'd0);
        chk("rr_no_tx", 32'(n_tx - base), 32'd0);
        lat = 3;
        run_req(32'h0000_0010, 1'b0, 1'b0, 32'h0, st, ws);
        chk("rr_after_hit", 32'(st), 32'd0);
        drop_req();

        // perf: two hits and one dirty miss after a fresh reset
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        run_req(32'h0000_0010, 1'b0, 1'b0, 32'h0, st, ws);
        run_req(32'h0000_0013, 1'b0, 1'b1, 32'h0, st, ws);
        base = n_tx;
        run_req(32'h0000_2010, 1'b0, 1'b0, 32'h0, st, ws);
        chk("pf_stalls", 32'(st), 32'd8);
        chk("pf_wb_addr", tx_addr[base], 32'h0000_0010);
        chk("pf_wb_data", tx_data[base], 32'h80FE_F00D);
        chk("pf_rdata", cpu_rdata, 32'hFFFF_DFEF);
        drop_req();
        @(negedge clk); #1;
`ifdef CACHE_CTRL_PERF_EN
        chk("perf_hits", perf_hits, 32'd2);
        chk("perf_misses", perf_misses, 32'd1);
        chk("perf_wbacks", perf_wbacks, 32'd1);
`else
        chk("perf_hits", perf_hits, 32'd0);
        chk("perf_misses", perf_misses, 32'd0);
        chk("perf_wbacks", perf_wbacks, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
